// File: rtl/ntt_pkg.sv
// Shared constants and types for the 256-point NTT address generator.
package ntt_pkg;

  localparam int unsigned N              = 256;
  localparam int unsigned LOG_N          = 8;
  localparam int unsigned NUM_STAGES     = 7;
  localparam int unsigned BFLY_PER_STAGE = 128;

  localparam int unsigned ADDR_W  = LOG_N;
  localparam int unsigned ZETA_W  = 7;
  localparam int unsigned STAGE_W = 3;
  localparam int unsigned BFLY_W  = 7;
  localparam int unsigned SHAMT_W = 4;

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [BFLY_W-1:0]  LAST_BFLY  = BFLY_W'(BFLY_PER_STAGE - 1);

  typedef enum logic {
    MODE_NTT  = 1'b0,
    MODE_INTT = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ntt_addr_calc.sv
// Combinational butterfly address and zeta index from (stage, butterfly, mode).
module ntt_addr_calc
  import ntt_pkg::*;
(
  input  logic [STAGE_W-1:0] stage,
  input  logic [BFLY_W-1:0]  bfly,
  input  mode_e              mode,
  output logic [ADDR_W-1:0]  addr_up,
  output logic [ADDR_W-1:0]  addr_dn,
  output logic [ZETA_W-1:0]  zeta_idx
);

  logic [SHAMT_W-1:0] log_len;
  logic [ADDR_W-1:0]  len;
  logic [ADDR_W-1:0]  grp;
  logic [ADDR_W-1:0]  ofs;
  logic [ADDR_W:0]    zeta_w;

  // len is a power of two, so divide/modulo reduce to shift/mask
  always_comb begin
    log_len  = (mode == MODE_NTT) ? (SHAMT_W'(7) - SHAMT_W'(stage))
                                  : (SHAMT_W'(stage) + SHAMT_W'(1));
    len      = ADDR_W'(1) << log_len;
    grp      = ADDR_W'(bfly) >> log_len;
    ofs      = ADDR_W'(bfly) & (len - ADDR_W'(1));
    addr_up  = ((grp << log_len) << 1) | ofs;
    addr_dn  = addr_up + len;
    if (mode == MODE_NTT) begin
      zeta_w = ((ADDR_W + 1)'(128) >> log_len) + (ADDR_W + 1)'(grp);
    end else begin
      zeta_w = ((ADDR_W + 1)'(256) >> log_len) - (ADDR_W + 1)'(1) - (ADDR_W + 1)'(grp);
    end
    zeta_idx = ZETA_W'(zeta_w);
  end

endmodule

// File: rtl/ntt_addrgen.sv
// NTT/INTT butterfly address and twiddle-index sequencer, one butterfly per clock.
// Optional macro ADDRGEN_PIPE_EN adds one output register stage to every output.
module ntt_addrgen
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              Sel,
  output logic [ADDR_W-1:0] addr_up,
  output logic [ADDR_W-1:0] addr_dn,
  output logic [ZETA_W-1:0] zeta_idx,
  output logic              done,
  output logic              last_stage,
  output logic              active
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [BFLY_W-1:0]   bfly_q, bfly_d;

  logic [ADDR_W-1:0]   addr_up_q, addr_up_d;
  logic [ADDR_W-1:0]   addr_dn_q, addr_dn_d;
  logic [ZETA_W-1:0]   zeta_idx_q, zeta_idx_d;
  logic                done_q, done_d;
  logic                last_stage_q, last_stage_d;
  logic                active_q, active_d;

  logic [ADDR_W-1:0]   calc_up_c;
  logic [ADDR_W-1:0]   calc_dn_c;
  logic [ZETA_W-1:0]   calc_zeta_c;

  // Addresses are computed from the next counter values so the registered
  // outputs line up with the butterfly the counters point at.
  ntt_addr_calc u_calc (
    .stage    (stage_d),
    .bfly     (bfly_d),
    .mode     (mode_d),
    .addr_up  (calc_up_c),
    .addr_dn  (calc_dn_c),
    .zeta_idx (calc_zeta_c)
  );

  // State, mode and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_NTT;
      stage_q <= '0;
      bfly_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
    end
  end

  // Next state: start latches mode, run walks b 0..127 per stage for 7 stages
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          mode_d  = mode_e'(Sel);
          stage_d = '0;
          bfly_d  = '0;
        end
      end
      RUN: begin
        if (bfly_q == LAST_BFLY) begin
          bfly_d = '0;
          if (stage_q == LAST_STAGE) begin
            state_d = IDLE;
            stage_d = '0;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
          end
        end else begin
          bfly_d = bfly_q + BFLY_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle; everything but done is zero while idle
  always_comb begin
    addr_up_d    = '0;
    addr_dn_d    = '0;
    zeta_idx_d   = '0;
    last_stage_d = 1'b0;
    active_d     = 1'b0;
    done_d       = (state_q == RUN) && (state_d == IDLE);
    if (state_d == RUN) begin
      active_d     = 1'b1;
      addr_up_d    = calc_up_c;
      addr_dn_d    = calc_dn_c;
      zeta_idx_d   = calc_zeta_c;
      last_stage_d = (stage_d == LAST_STAGE);
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_up_q    <= '0;
      addr_dn_q    <= '0;
      zeta_idx_q   <= '0;
      done_q       <= 1'b0;
      last_stage_q <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      addr_up_q    <= addr_up_d;
      addr_dn_q    <= addr_dn_d;
      zeta_idx_q   <= zeta_idx_d;
      done_q       <= done_d;
      last_stage_q <= last_stage_d;
      active_q     <= active_d;
    end
  end

`ifdef ADDRGEN_PIPE_EN
  logic [ADDR_W-1:0] addr_up_p_q;
  logic [ADDR_W-1:0] addr_dn_p_q;
  logic [ZETA_W-1:0] zeta_idx_p_q;
  logic              done_p_q;
  logic              last_stage_p_q;
  logic              active_p_q;

  // Extra output stage, all outputs delayed together
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_up_p_q    <= '0;
      addr_dn_p_q    <= '0;
      zeta_idx_p_q   <= '0;
      done_p_q       <= 1'b0;
      last_stage_p_q <= 1'b0;
      active_p_q     <= 1'b0;
    end else begin
      addr_up_p_q    <= addr_up_q;
      addr_dn_p_q    <= addr_dn_q;
      zeta_idx_p_q   <= zeta_idx_q;
      done_p_q       <= done_q;
      last_stage_p_q <= last_stage_q;
      active_p_q     <= active_q;
    end
  end

  assign addr_up    = addr_up_p_q;
  assign addr_dn    = addr_dn_p_q;
  assign zeta_idx   = zeta_idx_p_q;
  assign done       = done_p_q;
  assign last_stage = last_stage_p_q;
  assign active     = active_p_q;
`else
  assign addr_up    = addr_up_q;
  assign addr_dn    = addr_dn_q;
  assign zeta_idx   = zeta_idx_q;
  assign done       = done_q;
  assign last_stage = last_stage_q;
  assign active     = active_q;
`endif

endmodule

// File: tb/tb_ntt_addrgen.sv
// Directed bench for ntt_addrgen: spot butterflies, per-stage coverage, done/reset behaviour.
module tb_ntt_addrgen;

`ifdef ADDRGEN_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int TOTAL = 896;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic       Sel;
  logic [7:0] addr_up;
  logic [7:0] addr_dn;
  logic [6:0] zeta_idx;
  logic       done;
  logic       last_stage;
  logic       active;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] r_up [TOTAL];
  logic [7:0] r_dn [TOTAL];
  logic [6:0] r_z  [TOTAL];
  logic       r_ls [TOTAL];
  int         n_act;
  int         n_done_in_run;

  ntt_addrgen dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .Sel        (Sel),
    .addr_up    (addr_up),
    .addr_dn    (addr_dn),
    .zeta_idx   (zeta_idx),
    .done       (done),
    .last_stage (last_stage),
    .active     (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller sets i_start/Sel; this applies the start edge and records the run
  task automatic run_rec(input bit toggle);
    tick();
    i_start = 1'b0;
    for (int k = 1; k < LAT; k++) tick();
    n_act = 0;
    n_done_in_run = 0;
    while (active && n_act < 1000) begin
      if (n_act < TOTAL) begin
        r_up[n_act] = addr_up;
        r_dn[n_act] = addr_dn;
        r_z[n_act]  = zeta_idx;
        r_ls[n_act] = last_stage;
      end
      if (done) n_done_in_run++;
      n_act++;
      if (toggle && n_act < TOTAL - 4) begin
        i_start = 1'($urandom_range(0, 1));
        Sel     = 1'($urandom_range(0, 1));
      end else begin
        i_start = 1'b0;
      end
      tick();
    end
    i_start = 1'b0;
    chk("active_cycles", n_act, TOTAL);
    chk("done_during_run", n_done_in_run, 0);
    chk("done_pulse", int'(done), 1);
    chk("done_cycle_active", int'(active), 0);
    chk("done_cycle_addr", int'({addr_up, addr_dn, zeta_idx}), 0);
  endtask

  function automatic int pack3(input int up, input int dn, input int z);
    return (up << 16) | (dn << 8) | z;
  endfunction

  task automatic spot(input string tag, input int idx, input int up, input int dn, input int z);
    chk(tag, pack3(int'(r_up[idx]), int'(r_dn[idx]), int'(r_z[idx])), pack3(up, dn, z));
  endtask

  // Per stage: lower minus upper equals len, and the 128 pairs hit all 256 addresses once
  task automatic stage_props(input bit intt);
    for (int s = 0; s < 7; s++) begin
      bit seen [256];
      int len, bad, cov;
      len = intt ? (2 << s) : (128 >> s);
      bad = 0;
      cov = 0;
      for (int a = 0; a < 256; a++) seen[a] = 1'b0;
      for (int b = 0; b < 128; b++) begin
        int idx;
        idx = s * 128 + b;
        if (int'(r_dn[idx]) - int'(r_up[idx]) != len) bad++;
        if (seen[r_up[idx]] || seen[r_dn[idx]]) bad++;
        seen[r_up[idx]] = 1'b1;
        seen[r_dn[idx]] = 1'b1;
        if (int'(r_ls[idx]) != (s == 6 ? 1 : 0)) bad++;
      end
      for (int a = 0; a < 256; a++) cov += int'(seen[a]);
      chk($sformatf("stage%0d_cover", s), cov, 256);
      chk($sformatf("stage%0d_bad", s), bad, 0);
    end
  endtask

  task automatic ntt_spots();
    spot("ntt_b0", 0, 0, 128, 1);
    spot("ntt_b1", 1, 1, 129, 1);
    spot("ntt_b2", 2, 2, 130, 1);
    spot("ntt_s1_b0", 128, 0, 64, 2);
    spot("ntt_s1_b64", 192, 128, 192, 3);
    spot("ntt_s6_first", 768, 0, 2, 64);
    spot("ntt_s6_last", 895, 253, 255, 127);
    chk("ntt_ls_767", int'(r_ls[767]), 0);
    chk("ntt_ls_768", int'(r_ls[768]), 1);
  endtask

  initial begin
    int dcnt;
    rst = 1'b1;
    i_start = 1'b0;
    Sel = 1'b0;
    repeat (5) tick();
    chk("rst_addr_up", int'(addr_up), 0);
    chk("rst_addr_dn", int'(addr_dn), 0);
    chk("rst_zeta", int'(zeta_idx), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_last_stage", int'(last_stage), 0);
    chk("rst_active", int'(active), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_outputs", int'({addr_up, addr_dn, zeta_idx, done, last_stage, active}), 0);

    // Forward NTT
    i_start = 1'b1;
    Sel = 1'b0;
    run_rec(1'b0);
    ntt_spots();
    stage_props(1'b0);

    // INTT started in the done cycle of the previous run
    i_start = 1'b1;
    Sel = 1'b1;
    run_rec(1'b0);
    spot("intt_b0", 0, 0, 2, 127);
    spot("intt_b1", 1, 1, 3, 127);
    spot("intt_b2", 2, 4, 6, 126);
    spot("intt_s6_first", 768, 0, 128, 1);
    spot("intt_s6_last", 895, 127, 255, 1);
    stage_props(1'b1);
    Sel = 1'b0;
    tick();
    chk("after_done_pulse", int'({done, active}), 0);

    // NTT with i_start and Sel toggling throughout the run
    repeat (2) tick();
    i_start = 1'b1;
    Sel = 1'b0;
    run_rec(1'b1);
    ntt_spots();
    stage_props(1'b0);
    tick();
    chk("toggle_no_restart", int'(active), 0);

    // Reset during a run
    repeat (2) tick();
    i_start = 1'b1;
    Sel = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (299) tick();
    chk("pre_rst_active", int'(active), 1);
    rst = 1'b1;
    tick();
    chk("midrst_outputs", int'({addr_up, addr_dn, zeta_idx, done, last_stage, active}), 0);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done || active) dcnt++;
    end
    chk("midrst_no_done", dcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
